// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
// Sprite-DMA engine and bus arbiter between the 2A03 CPU core and the
// external memory bus. A CPU write to DMA_TRIG_ADDR latches a source page.
// The block then stalls the CPU through cpu_rdy and copies 256 bytes from
// {page, 00..FF} to OAM_DATA_ADDR as alternating get/put cycles.
//
// Ports:
//   clk        in   system clock, all flops rise-edge
//   rst_n      in   asynchronous active-low reset
//   cpu_addr   in   [15:0] CPU address bus
//   cpu_dout   in   [7:0]  CPU write data
//   cpu_rw     in   CPU direction, 1=read 0=write
//   cpu_rdy    out  CPU ready; 0 stalls CPU read cycles
//   mem_din    in   [7:0]  read data from the memory bus
//   bus_addr   out  [15:0] arbitrated address
//   bus_dout   out  [7:0]  arbitrated write data
//   bus_rw     out  arbitrated direction, 1=read
//   dma_active out  high whenever a transfer is in progress
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    input  logic [7:0]  mem_din,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  page_r;
    logic [7:0]  page_nxt_s;
    logic [7:0]  idx_r;
    logic [7:0]  idx_nxt_s;
    logic [7:0]  data_r;
    logic [7:0]  data_nxt_s;
    logic        par_r;
    logic        trig_s;

    assign trig_s = (cpu_rw == 1'b0) && (cpu_addr == DMA_TRIG_ADDR);

    // State, source page, byte index, data latch and free-running slot parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            page_r  <= 8'h00;
            idx_r   <= 8'h00;
            data_r  <= 8'h00;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            page_r  <= page_nxt_s;
            idx_r   <= idx_nxt_s;
            data_r  <= data_nxt_s;
            // par=0 marks a get slot, par=1 a put slot; runs in every state
            par_r   <= ~par_r;
        end
    end

    // Next-state decode and bus steering
    always_comb begin
        state_nxt_s = state_r;
        page_nxt_s  = page_r;
        idx_nxt_s   = idx_r;
        data_nxt_s  = data_r;
        bus_addr    = cpu_addr;
        bus_dout    = cpu_dout;
        bus_rw      = cpu_rw;
        case (state_r)
            ST_IDLE: begin
                if (trig_s) begin
                    page_nxt_s  = cpu_dout;
                    idx_nxt_s   = 8'h00;
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                // A CPU write cannot be halted; wait for its first read cycle.
                // Triggers seen here are deliberately ignored.
                if (cpu_rw) begin
                    state_nxt_s = par_r ? ST_READ : ST_ALIGN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_ALIGN: begin
                bus_rw      = 1'b1;
                state_nxt_s = ST_READ;
            end
            ST_READ: begin
                bus_addr    = {page_r, idx_r};
                bus_rw      = 1'b1;
                data_nxt_s  = mem_din;
                state_nxt_s = ST_WRITE;
            end
            ST_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_dout  = data_r;
                bus_rw    = 1'b0;
                idx_nxt_s = idx_r + 8'd1;
                if (idx_r == 8'hFF) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign cpu_rdy    = (state_r == ST_IDLE);
    assign dma_active = (state_r != ST_IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_arbiter
// Self-checking bench for oam_dma_arbiter. A behavioural model tracks the
// transfer as "waiting for halt" plus a slot counter (-1 = dummy, 0..511 =
// alternating get/put) and predicts the bus every cycle. Memory returns
// low-address-byte XOR mem_key.
// ---------------------------------------------------------------------------
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic [7:0]  mem_din;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_rw;
    logic        dma_active;

    logic [7:0]  mem_key;

    int test_cnt;
    int fail_cnt;

    // model state
    logic        busy_m;
    logic        halted_m;
    int          slot_m;
    logic [7:0]  page_m;
    logic        par_m;

    // observation counters
    int rdy_low_cnt;
    int oam_wr_cnt;
    int dummy_cnt;
    int halt_wr_cnt;
    int src_bad_cnt;
    logic [7:0] src_page_exp;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_rw     (cpu_rw),
        .cpu_rdy    (cpu_rdy),
        .mem_din    (mem_din),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_rw     (bus_rw),
        .dma_active (dma_active)
    );

    assign mem_din = bus_addr[7:0] ^ mem_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_obs(input logic [7:0] pg);
        rdy_low_cnt  = 0;
        oam_wr_cnt   = 0;
        dummy_cnt    = 0;
        halt_wr_cnt  = 0;
        src_bad_cnt  = 0;
        src_page_exp = pg;
    endtask

    task automatic model_reset();
        busy_m   = 1'b0;
        halted_m = 1'b0;
        slot_m   = 0;
        page_m   = 8'h00;
        par_m    = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_rdy",    32'(cpu_rdy),    32'd1);
        check_val("rst_active", 32'(dma_active), 32'd0);
        check_val("rst_addr",   32'(bus_addr),   32'(cpu_addr));
        check_val("rst_rw",     32'(bus_rw),     32'(cpu_rw));
        check_val("rst_dout",   32'(bus_dout),   32'(cpu_dout));
    endtask

    // Drive one CPU cycle, compare against the model, advance the model.
    // Called just after a falling edge; returns before the next one.
    task automatic drive_and_check(input logic [15:0] a, input logic [7:0] d, input logic rw);
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        logic        e_rw;
        logic        e_rdy;
        logic        chk_dout;
        logic [7:0]  byte_idx;
        cpu_addr = a;
        cpu_dout = d;
        cpu_rw   = rw;
        #1;
        e_addr   = a;
        e_dout   = d;
        e_rw     = rw;
        e_rdy    = !busy_m;
        chk_dout = 1'b1;
        byte_idx = 8'(slot_m / 2);
        if (busy_m && halted_m) begin
            if (slot_m < 0) begin
                e_rw = 1'b1;
            end else if ((slot_m % 2) == 0) begin
                e_addr   = {page_m, byte_idx};
                e_rw     = 1'b1;
                chk_dout = 1'b0;
            end else begin
                e_addr = 16'h2004;
                e_rw   = 1'b0;
                e_dout = byte_idx ^ mem_key;
            end
        end
        check_val("bus_addr",   32'(bus_addr),   32'(e_addr));
        check_val("bus_rw",     32'(bus_rw),     32'(e_rw));
        check_val("cpu_rdy",    32'(cpu_rdy),    32'(e_rdy));
        check_val("dma_active", 32'(dma_active), 32'(!e_rdy));
        if (chk_dout) check_val("bus_dout", 32'(bus_dout), 32'(e_dout));

        // observations straight from the DUT pins
        if (!cpu_rdy) rdy_low_cnt++;
        if (dma_active && !bus_rw && bus_addr == 16'h2004) oam_wr_cnt++;
        if (!cpu_rdy && bus_rw && bus_addr == cpu_addr) dummy_cnt++;
        if (!cpu_rdy && !bus_rw && bus_addr != 16'h2004) halt_wr_cnt++;
        if (dma_active && bus_rw && bus_addr != cpu_addr && bus_addr[15:8] != src_page_exp) src_bad_cnt++;

        // advance model
        if (!busy_m) begin
            if (!rw && a == 16'h4014) begin
                busy_m   = 1'b1;
                halted_m = 1'b0;
                page_m   = d;
            end
        end else if (!halted_m) begin
            if (rw) begin
                halted_m = 1'b1;
                slot_m   = par_m ? 0 : -1;
            end
        end else begin
            slot_m++;
            if (slot_m == 512) busy_m = 1'b0;
        end
        par_m = ~par_m;
    endtask

    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic rw);
        drive_and_check(a, d, rw);
        @(negedge clk);
    endtask

    task automatic sync_par(input logic want);
        if (par_m != want) step(16'h8000, 8'h00, 1'b1);
    endtask

    // CPU keeps reading $8000 until the DUT drops dma_active (bounded)
    task automatic run_until_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 700; i++) begin
            drive_and_check(16'h8000, 8'h00, 1'b1);
            @(negedge clk);
            if (!dma_active) begin
                done = 1'b1;
                break;
            end
        end
        check_val("xfer_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        logic p;
        test_cnt = 0;
        fail_cnt = 0;
        mem_key  = 8'h00;
        model_reset();
        clear_obs(8'h02);

        // reset
        rst_n    = 1'b0;
        cpu_addr = 16'h8000;
        cpu_dout = 8'h00;
        cpu_rw   = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // idle passthrough
        for (int i = 0; i < 10; i++) step(16'h8000, 8'h00, 1'b1);

        // trigger at par=0
        sync_par(1'b0);
        clear_obs(8'h02);
        step(16'h4014, 8'h02, 1'b0);
        run_until_idle();
        check_val("stall_par0", 32'(rdy_low_cnt), 32'd513);
        check_val("oam_wr_par0", 32'(oam_wr_cnt), 32'd256);
        check_val("dummy_par0", 32'(dummy_cnt), 32'd1);
        check_val("src_par0", 32'(src_bad_cnt), 32'd0);

        // trigger at par=1, one ALIGN cycle
        sync_par(1'b1);
        clear_obs(8'h02);
        step(16'h4014, 8'h02, 1'b0);
        run_until_idle();
        check_val("stall_par1", 32'(rdy_low_cnt), 32'd514);
        check_val("oam_wr_par1", 32'(oam_wr_cnt), 32'd256);
        check_val("dummy_par1", 32'(dummy_cnt), 32'd2);

        // trigger followed by two stack pushes
        p = 1'($urandom_range(0, 1));
        sync_par(p);
        clear_obs(8'h02);
        step(16'h4014, 8'h02, 1'b0);
        step(16'h0100, 8'hA5, 1'b0);
        step(16'h01FF, 8'h5A, 1'b0);
        run_until_idle();
        check_val("stall_push", 32'(rdy_low_cnt), 32'(515 + int'(p)));
        check_val("halt_wr_push", 32'(halt_wr_cnt), 32'd2);
        check_val("oam_wr_push", 32'(oam_wr_cnt), 32'd256);

        // reset on the 40th WRITE
        mem_key = 8'h3C;
        clear_obs(8'h02);
        step(16'h4014, 8'h02, 1'b0);
        for (int i = 0; i < 700; i++) begin
            drive_and_check(16'h8000, 8'h00, 1'b1);
            if (oam_wr_cnt == 40) break;
            @(negedge clk);
        end
        check_val("mid_wr40", 32'(oam_wr_cnt), 32'd40);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_obs(8'h02);
        for (int i = 0; i < 600; i++) step(16'h8000, 8'h00, 1'b1);
        check_val("post_rst_oam", 32'(oam_wr_cnt), 32'd0);
        check_val("post_rst_stall", 32'(rdy_low_cnt), 32'd0);

        // retrigger attempt during HALT is ignored
        clear_obs(8'h02);
        step(16'h4014, 8'h02, 1'b0);
        step(16'h4014, 8'h05, 1'b0);
        run_until_idle();
        check_val("halt_trig_src", 32'(src_bad_cnt), 32'd0);
        check_val("halt_trig_oam", 32'(oam_wr_cnt), 32'd256);

        // randomized CPU traffic against the model
        mem_key = 8'($urandom);
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [15:0] ra;
            r  = int'($urandom_range(0, 99));
            ra = 16'($urandom);
            src_page_exp = page_m;
            if (r < 3) begin
                step(16'h4014, 8'($urandom), 1'b0);
            end else if (r < 25) begin
                step(ra, 8'($urandom), 1'b0);
            end else begin
                step(ra, 8'($urandom), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
